vec_issue_ctrl: RTL and testbench

In-order issue controller for the vector datapath: vector register file, vector data memory, VMAC unit and the write-back select mux. It accepts one decoded vector instruction per cycle and stalls the decoder on register hazards and write-back port conflicts. It tracks in-flight results in a latency-matched pending pipeline and drives the vector register write enable, write address and mux select in the cycle each result arrives. It sits between decode and the vector register file write port.

---
 rtl/vec_pkg.sv | 24 ++
 rtl/vreg_scoreboard.sv | 43 ++++
 rtl/vec_issue_ctrl.sv | 119 +++++++++++
 tb/tb_vec_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared op encoding, write-back select values and default latencies
package vec_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_VMAC   = 2'b01,
    OP_VLOAD  = 2'b10,
    OP_VSTORE = 2'b11
  } vec_op_e;

  localparam logic SEL_MEM  = 1'b0;
  localparam logic SEL_VMAC = 1'b1;

  localparam int DEF_VREGAW   = 3;
  localparam int DEF_VMAC_LAT = 3;
  localparam int DEF_VLD_LAT  = 1;
  localparam int DEF_CNTW     = 16;

  // VMAC and VLOAD produce a register result; VSTORE and NOP do not.
  function automatic logic op_writes_reg(vec_op_e op);
    return (op == OP_VMAC) || (op == OP_VLOAD);
  endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// rtl/vreg_scoreboard.sv - per-register busy bits with set/clear and three lookup ports
module vreg_scoreboard #(
  parameter int VREGAW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [VREGAW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [VREGAW-1:0] clr_addr,
  input  logic [VREGAW-1:0] rd0_addr,
  input  logic [VREGAW-1:0] rd1_addr,
  input  logic [VREGAW-1:0] rd2_addr,
  output logic              rd0_busy,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              any_busy
);

  localparam int VREGN = 1 << VREGAW;

  logic [VREGN-1:0] busy_q;
  logic [VREGN-1:0] busy_d;

  // Clear on write-back, set on issue; the hazard rules keep both off the same bit.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  // Busy-bit array register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rd0_busy = busy_q[rd0_addr];
  assign rd1_busy = busy_q[rd1_addr];
  assign rd2_busy = busy_q[rd2_addr];
  assign any_busy = |busy_q;

endmodule

// File: rtl/vec_issue_ctrl.sv
// rtl/vec_issue_ctrl.sv - in-order vector issue control with hazard stall and write-back pipeline
module vec_issue_ctrl import vec_pkg::*; #(
  parameter int VREGAW   = DEF_VREGAW,
  parameter int VMAC_LAT = DEF_VMAC_LAT,
  parameter int VLD_LAT  = DEF_VLD_LAT,
  parameter int CNTW     = DEF_CNTW
) (
  input  logic              Clk_i,
  input  logic              Rst_n_i,
  input  logic              Issue_valid_i,
  input  logic [1:0]        Issue_op_i,
  input  logic [VREGAW-1:0] VRdAddr_i,
  input  logic [VREGAW-1:0] VRs1Addr_i,
  input  logic [VREGAW-1:0] VRs2Addr_i,
  output logic              Issue_ready_o,
  output logic              VDcmWEn_o,
  output logic              VRegWEn_o,
  output logic [VREGAW-1:0] VRdAddr_o,
  output logic              Mux2_s_o,
  output logic              Busy_o,
  output logic [CNTW-1:0]   StallCnt_o
);

  vec_op_e op;
  logic    is_vmac, is_vload, is_vstore, has_dest;
  logic    rs1_busy, rs2_busy, rd_busy, any_reg_busy;
  logic    raw_hazard, waw_hazard, port_conflict;
  logic    accept, stall;

  // Slot k holds the write-back that lands k cycles from now; slot 0 is the output.
  logic [VMAC_LAT-1:0] slot_valid_q, slot_valid_d;
  logic [VMAC_LAT-1:0] slot_sel_q, slot_sel_d;
  logic [VREGAW-1:0]   slot_addr_q [VMAC_LAT];
  logic [VREGAW-1:0]   slot_addr_d [VMAC_LAT];
  logic [VMAC_LAT:0]   slot_valid_ext;
  logic [CNTW-1:0]     stall_cnt_q, stall_cnt_d;

  assign op        = vec_op_e'(Issue_op_i);
  assign is_vmac   = (op == OP_VMAC);
  assign is_vload  = (op == OP_VLOAD);
  assign is_vstore = (op == OP_VSTORE);
  assign has_dest  = op_writes_reg(op);

  vreg_scoreboard #(.VREGAW(VREGAW)) u_scoreboard (
    .clk      (Clk_i),
    .rst_n    (Rst_n_i),
    .set_en   (accept & has_dest),
    .set_addr (VRdAddr_i),
    .clr_en   (slot_valid_q[0]),
    .clr_addr (slot_addr_q[0]),
    .rd0_addr (VRs1Addr_i),
    .rd1_addr (VRs2Addr_i),
    .rd2_addr (VRdAddr_i),
    .rd0_busy (rs1_busy),
    .rd1_busy (rs2_busy),
    .rd2_busy (rd_busy),
    .any_busy (any_reg_busy)
  );

  // A phantom always-empty slot VMAC_LAT lets the load check index uniformly,
  // including VLD_LAT == VMAC_LAT. VMAC needs no port check: its slot is the
  // top one, which is always free after the shift.
  assign slot_valid_ext = {1'b0, slot_valid_q};

  assign raw_hazard    = (is_vmac & (rs1_busy | rs2_busy)) | (is_vstore & rs1_busy);
  assign waw_hazard    = has_dest & rd_busy;
  assign port_conflict = is_vload & slot_valid_ext[VLD_LAT];

  assign Issue_ready_o = ~(Issue_valid_i & (raw_hazard | waw_hazard | port_conflict));
  assign accept        = Issue_valid_i & Issue_ready_o;
  assign stall         = Issue_valid_i & ~Issue_ready_o;
  assign VDcmWEn_o     = accept & is_vstore;

  // Shift the pending pipeline down one slot and insert the newly accepted result.
  always_comb begin
    slot_valid_d = slot_valid_q >> 1;
    slot_sel_d   = slot_sel_q >> 1;
    for (int k = 0; k < VMAC_LAT; k++) slot_addr_d[k] = '0;
    for (int k = 0; k < VMAC_LAT - 1; k++) slot_addr_d[k] = slot_addr_q[k+1];
    if (accept & is_vmac) begin
      slot_valid_d[VMAC_LAT-1] = 1'b1;
      slot_addr_d[VMAC_LAT-1]  = VRdAddr_i;
      slot_sel_d[VMAC_LAT-1]   = SEL_VMAC;
    end
    if (accept & is_vload) begin
      slot_valid_d[VLD_LAT-1] = 1'b1;
      slot_addr_d[VLD_LAT-1]  = VRdAddr_i;
      slot_sel_d[VLD_LAT-1]   = SEL_MEM;
    end
  end

  // Saturating count of cycles the decoder was held off.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  // Pending pipeline and stall counter registers; reset drops all pending write-backs.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      slot_valid_q <= '0;
      slot_sel_q   <= '0;
      for (int k = 0; k < VMAC_LAT; k++) slot_addr_q[k] <= '0;
      stall_cnt_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_sel_q   <= slot_sel_d;
      for (int k = 0; k < VMAC_LAT; k++) slot_addr_q[k] <= slot_addr_d[k];
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign VRegWEn_o  = slot_valid_q[0];
  assign VRdAddr_o  = slot_addr_q[0];
  assign Mux2_s_o   = slot_sel_q[0];
  assign Busy_o     = (|slot_valid_q) | any_reg_busy;
  assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb/tb_vec_issue_ctrl.sv - directed vector table plus random stimulus against a cycle-schedule model
module tb_vec_issue_ctrl;
  import vec_pkg::*;

  localparam int VREGAW   = 3;
  localparam int VMAC_LAT = 3;
  localparam int VLD_LAT  = 1;
  localparam int CNTW     = 8;
  localparam int CNTMAX   = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              iv = 1'b0;
  logic [1:0]        iop = 2'b00;
  logic [VREGAW-1:0] ird = '0, irs1 = '0, irs2 = '0;
  logic              Issue_ready_o, VDcmWEn_o, VRegWEn_o, Mux2_s_o, Busy_o;
  logic [VREGAW-1:0] VRdAddr_o;
  logic [CNTW-1:0]   StallCnt_o;

  always #5 clk = ~clk;

  vec_issue_ctrl #(
    .VREGAW(VREGAW), .VMAC_LAT(VMAC_LAT), .VLD_LAT(VLD_LAT), .CNTW(CNTW)
  ) dut (
    .Clk_i         (clk),
    .Rst_n_i       (rst_n),
    .Issue_valid_i (iv),
    .Issue_op_i    (iop),
    .VRdAddr_i     (ird),
    .VRs1Addr_i    (irs1),
    .VRs2Addr_i    (irs2),
    .Issue_ready_o (Issue_ready_o),
    .VDcmWEn_o     (VDcmWEn_o),
    .VRegWEn_o     (VRegWEn_o),
    .VRdAddr_o     (VRdAddr_o),
    .Mux2_s_o      (Mux2_s_o),
    .Busy_o        (Busy_o),
    .StallCnt_o    (StallCnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;

  // Reference model: every accepted result is a scheduled write at an absolute cycle.
  longint      wbc [8];          // cycle in which each register is written back
  int unsigned wb_addr [longint];
  bit          wb_sel  [longint];
  longint      last_wb;
  int          cnt_m;
  bit          m_ready;

  logic o_ready, o_dcm, o_wen, o_sel, o_busy;
  logic [VREGAW-1:0] o_addr;
  logic [CNTW-1:0]   o_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (wbc[r]) wbc[r] = -1;
    wb_addr.delete();
    wb_sel.delete();
    last_wb = -1;
    cnt_m = 0;
  endtask

  function automatic bit busy_m(input logic [VREGAW-1:0] r);
    return wbc[r] >= cyc;
  endfunction

  // One clock cycle: drive, sample mid-cycle, compare to model, advance model.
  task automatic step(input bit v, input logic [1:0] op, input logic [VREGAW-1:0] rd,
                      input logic [VREGAW-1:0] rs1, input logic [VREGAW-1:0] rs2, input bit chk_m);
    int L;
    bit hz, e_wen, e_dcm, e_busy;
    iv = v; iop = op; ird = rd; irs1 = rs1; irs2 = rs2;
    @(negedge clk);
    o_ready = Issue_ready_o; o_dcm = VDcmWEn_o; o_wen = VRegWEn_o;
    o_addr = VRdAddr_o; o_sel = Mux2_s_o; o_busy = Busy_o; o_cnt = StallCnt_o;
    L = (op == OP_VMAC) ? VMAC_LAT : VLD_LAT;
    case (op)
      OP_VMAC:   hz = busy_m(rs1) || busy_m(rs2) || busy_m(rd) || (wb_addr.exists(cyc + L) != 0);
      OP_VLOAD:  hz = busy_m(rd) || (wb_addr.exists(cyc + L) != 0);
      OP_VSTORE: hz = busy_m(rs1);
      default:   hz = 1'b0;
    endcase
    m_ready = !(v && hz);
    e_wen   = wb_addr.exists(cyc) != 0;
    e_busy  = last_wb >= cyc;
    e_dcm   = v && m_ready && (op == OP_VSTORE);
    if (chk_m) begin
      chk("m_ready", 32'(o_ready), 32'(m_ready));
      chk("m_wen",   32'(o_wen),   32'(e_wen));
      if (e_wen) begin
        chk("m_addr", 32'(o_addr), wb_addr[cyc]);
        chk("m_sel",  32'(o_sel),  32'(wb_sel[cyc]));
      end
      chk("m_busy",  32'(o_busy),  32'(e_busy));
      chk("m_dcm",   32'(o_dcm),   32'(e_dcm));
      chk("m_cnt",   32'(o_cnt),   32'(cnt_m));
    end
    if (v && !m_ready && cnt_m < CNTMAX) cnt_m++;
    if (v && m_ready && (op == OP_VMAC || op == OP_VLOAD)) begin
      wb_addr[cyc + L] = rd;
      wb_sel[cyc + L]  = (op == OP_VMAC);
      wbc[rd] = cyc + L;
      if (cyc + L > last_wb) last_wb = cyc + L;
    end
    if (wb_addr.exists(cyc) != 0) begin
      wb_addr.delete(cyc);
      wb_sel.delete(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit v; logic [1:0] op; logic [2:0] rd, rs1, rs2;
    bit ready, dcm, wen; logic [2:0] addr; bit sel, busy; int cnt;
  } vec_t;

  function automatic vec_t mk(bit v, logic [1:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2,
                              bit ready, bit dcm, bit wen, logic [2:0] addr, bit sel, bit busy, int cnt);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.ready = ready; t.dcm = dcm; t.wen = wen; t.addr = addr; t.sel = sel; t.busy = busy; t.cnt = cnt;
    return t;
  endfunction

  vec_t tbl [23];
  bit   hold_v;
  logic [1:0] r_op;
  logic [2:0] r_rd, r_rs1, r_rs2;

  initial begin
    // VMAC latency and busy window
    tbl[0]  = mk(1, OP_VMAC,   3, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, OP_NOP,    7, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, OP_NOP,    0, 0, 0, 1, 0, 1, 3, 1, 1, 0);
    tbl[4]  = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // RAW on a VSTORE source, busy through its own write-back cycle
    tbl[5]  = mk(1, OP_VMAC,   3, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, OP_VSTORE, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, OP_VSTORE, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, OP_VSTORE, 0, 3, 0, 0, 0, 1, 3, 1, 1, 2);
    tbl[9]  = mk(1, OP_VSTORE, 0, 3, 0, 1, 1, 0, 0, 0, 0, 3);
    // Write-port conflict between VMAC and VLOAD
    tbl[10] = mk(1, OP_VMAC,   2, 0, 1, 1, 0, 0, 0, 0, 0, 3);
    tbl[11] = mk(1, OP_VLOAD,  6, 0, 0, 1, 0, 0, 0, 0, 1, 3);
    tbl[12] = mk(1, OP_VLOAD,  5, 0, 0, 0, 0, 1, 6, 0, 1, 3);
    tbl[13] = mk(1, OP_VLOAD,  5, 0, 0, 1, 0, 1, 2, 1, 1, 4);
    tbl[14] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 1, 5, 0, 1, 4);
    tbl[15] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    // WAW behind a VLOAD
    tbl[16] = mk(1, OP_VLOAD,  4, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    tbl[17] = mk(1, OP_VMAC,   4, 0, 1, 0, 0, 1, 4, 0, 1, 4);
    tbl[18] = mk(1, OP_VMAC,   4, 0, 1, 1, 0, 0, 0, 0, 0, 5);
    tbl[19] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 5);
    tbl[20] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 5);
    tbl[21] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 1, 4, 1, 1, 5);
    tbl[22] = mk(0, OP_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 0, 5);

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b1);
      chk("t_ready", 32'(o_ready), 32'(tbl[i].ready));
      chk("t_dcm",   32'(o_dcm),   32'(tbl[i].dcm));
      chk("t_wen",   32'(o_wen),   32'(tbl[i].wen));
      if (tbl[i].wen) begin
        chk("t_addr", 32'(o_addr), 32'(tbl[i].addr));
        chk("t_sel",  32'(o_sel),  32'(tbl[i].sel));
      end
      chk("t_busy",  32'(o_busy),  32'(tbl[i].busy));
      chk("t_cnt",   32'(o_cnt),   tbl[i].cnt);
    end

    // Saturation: a self-dependent VMAC held valid stalls three of every four cycles.
    for (int i = 0; i < 400; i++) step(1, OP_VMAC, 7, 7, 7, 1'b1);
    step(0, OP_NOP, 0, 0, 0, 1'b1);
    chk("stall_sat", 32'(o_cnt), CNTMAX);
    step(1, OP_VSTORE, 0, 7, 0, 1'b1);
    step(1, OP_VSTORE, 0, 7, 0, 1'b1);
    chk("stall_sat_hold", 32'(o_cnt), CNTMAX);

    // Random traffic; decode holds its instruction while stalled.
    hold_v = 1'b0;
    r_op = OP_NOP; r_rd = '0; r_rs1 = '0; r_rs2 = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold_v) begin
        r_op  = 2'($urandom_range(0, 3));
        r_rd  = 3'($urandom_range(0, 3));
        r_rs1 = 3'($urandom_range(0, 3));
        r_rs2 = 3'($urandom_range(0, 3));
      end
      if (hold_v || ($urandom_range(0, 3) != 0)) begin
        step(1, r_op, r_rd, r_rs1, r_rs2, 1'b1);
        hold_v = !m_ready;
      end else begin
        step(0, r_op, r_rd, r_rs1, r_rs2, 1'b1);
      end
    end

    // Reset while results are in flight drops them all.
    for (int i = 0; i < 5; i++) step(0, OP_NOP, 0, 0, 0, 1'b1);
    step(1, OP_VMAC, 1, 2, 3, 1'b1);
    step(1, OP_VLOAD, 2, 0, 0, 1'b1);
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wen",  32'(VRegWEn_o), 0);
    chk("rst_async_busy", 32'(Busy_o), 0);
    chk("rst_async_cnt",  32'(StallCnt_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc += 3;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, OP_NOP, 0, 0, 0, 1'b1);
      chk("post_rst_wen",  32'(o_wen), 0);
      chk("post_rst_busy", 32'(o_busy), 0);
      chk("post_rst_cnt",  32'(o_cnt), 0);
    end
    step(1, OP_VMAC, 1, 2, 3, 1'b1);
    chk("post_rst_ready", 32'(o_ready), 1);
    for (int i = 0; i < 4; i++) step(0, OP_NOP, 0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
